// File: rtl/block_header_link_host_pkg.sv
// Shared constants, state encoding and training-sequence helper for the miner serial link.
// Used by the host-side framer and the receive-side framer.
package header_link_pkg;

  localparam int HDR_BYTES  = 80;
  localparam int RESP_BYTES = 32;
  localparam int HDR_W      = HDR_BYTES * 8;
  localparam int RESP_W     = RESP_BYTES * 8;

  localparam logic [31:0] TS_WORD                = 32'h61626364;
  localparam logic [31:0] TIMEOUT_CYCLES_DEFAULT = 32'd100_000_000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_TS   = 2'd1,
    SEND_HDR  = 2'd2,
    WAIT_RESP = 2'd3
  } state_t;

  // Training sequence byte i, where i=3 is the first byte on the wire.
  function automatic logic [7:0] ts_byte(input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd3:    b = TS_WORD[31:24];
      2'd2:    b = TS_WORD[23:16];
      2'd1:    b = TS_WORD[15:8];
      default: b = TS_WORD[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/block_header_link_host_if.sv
// Header-in / byte-stream / hash-out bundle of the link host.
// slave = the link host itself, master = whoever drives it (system or bench).
interface block_header_link_host_if;
  import header_link_pkg::*;

  logic [HDR_W-1:0]  hdr_in;
  logic              hdr_valid;
  logic              hdr_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [RESP_W-1:0] hash_out;
  logic              hash_valid;
  logic              busy;
  logic              timeout;

  modport slave (
    input  hdr_in, hdr_valid, tx_ready, rx_data, rx_valid,
    output hdr_ready, tx_data, tx_valid, hash_out, hash_valid, busy, timeout
  );

  modport master (
    output hdr_in, hdr_valid, tx_ready, rx_data, rx_valid,
    input  hdr_ready, tx_data, tx_valid, hash_out, hash_valid, busy, timeout
  );
endinterface

// File: rtl/block_header_link_host_byte_shift_collector.sv
// MSB-first byte deserializer: DEPTH bytes in, first byte ends up in the top byte of o_word.
// o_done is asserted combinationally with the last byte; o_word already includes it.
module byte_shift_collector
  import header_link_pkg::*;
#(
  parameter int DEPTH = RESP_BYTES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_en,
  input  logic [7:0]         i_data,
  output logic [DEPTH*8-1:0] o_word,
  output logic               o_done
);
  localparam int IW = $clog2(DEPTH);

  logic [DEPTH*8-1:0] r_shift;
  logic [IW-1:0]      r_idx;

  assign o_word = {r_shift[DEPTH*8-9:0], i_data};
  assign o_done = i_en && (r_idx == '0);

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_shift <= '0;
      r_idx   <= IW'(DEPTH - 1);
    end else if (i_en) begin
      r_shift <= o_word;
      r_idx   <= o_done ? IW'(DEPTH - 1) : r_idx - 1'b1;
    end
  end

endmodule

// File: rtl/block_header_link_host.sv
// Host end of the miner serial link: sends "abcd" + 80-byte header, collects the 32-byte hash reply.
// Optional RESP_TIMEOUT_EN adds an inter-byte reply timeout (TIMEOUT_CYCLES).
//
// state     | meaning
// IDLE      | ready for a new header
// SEND_TS   | sending the 4-byte training sequence
// SEND_HDR  | sending the 80 header bytes
// WAIT_RESP | collecting the 32-byte hash reply
module block_header_link_host
  import header_link_pkg::*;
`ifdef RESP_TIMEOUT_EN
#(
  parameter logic [31:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
)
`endif
(
  input logic                    clk,
  input logic                    rst,
  block_header_link_host_if.slave link
);

  state_t             r_state, w_state_nxt;
  logic [6:0]         r_idx, w_idx_nxt;
  logic [6:0]         w_idx_m1;
  logic [HDR_W-1:0]   r_hdr;
  logic               w_hdr_load;
  logic [7:0]         r_tx_data, w_tx_data_nxt;
  logic               r_tx_valid, w_tx_valid_nxt;
  logic               w_tx_fire;
  logic [RESP_W-1:0]  r_hash;
  logic               r_hash_valid;
  logic               r_timeout, w_timeout_nxt;
  logic               w_rx_en;
  logic               w_rx_done;
  logic [RESP_W-1:0]  w_rx_word;
  logic               w_to_hit;

  assign w_tx_fire = r_tx_valid && link.tx_ready;
  assign w_idx_m1  = r_idx - 7'd1;
  assign w_rx_en   = link.rx_valid && (r_state == WAIT_RESP);

  byte_shift_collector #(.DEPTH(RESP_BYTES)) u_collect (
    .clk     (clk),
    .rst     (rst),
    .i_clear (r_state != WAIT_RESP),
    .i_en    (w_rx_en),
    .i_data  (link.rx_data),
    .o_word  (w_rx_word),
    .o_done  (w_rx_done)
  );

`ifdef RESP_TIMEOUT_EN
  logic [31:0] r_to_cnt;

  always_ff @(posedge clk) begin
    if (rst || (r_state != WAIT_RESP) || link.rx_valid) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 32'd1;
    end
  end

  assign w_to_hit = (r_state == WAIT_RESP) && !link.rx_valid &&
                    (r_to_cnt == TIMEOUT_CYCLES - 32'd1);
`else
  assign w_to_hit = 1'b0;
`endif

  // tx_data is preloaded one step ahead so the byte is valid the cycle after each handshake.
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_tx_data_nxt  = r_tx_data;
    w_tx_valid_nxt = r_tx_valid;
    w_hdr_load     = 1'b0;
    w_timeout_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (link.hdr_valid) begin
          w_hdr_load     = 1'b1;
          w_idx_nxt      = 7'd3;
          w_tx_valid_nxt = 1'b1;
          w_tx_data_nxt  = ts_byte(2'd3);
          w_state_nxt    = SEND_TS;
        end
      end
      SEND_TS: begin
        if (w_tx_fire) begin
          if (r_idx == 7'd0) begin
            w_idx_nxt     = 7'(HDR_BYTES - 1);
            w_tx_data_nxt = r_hdr[HDR_W-1 -: 8];
            w_state_nxt   = SEND_HDR;
          end else begin
            w_idx_nxt     = w_idx_m1;
            w_tx_data_nxt = ts_byte(w_idx_m1[1:0]);
          end
        end
      end
      SEND_HDR: begin
        if (w_tx_fire) begin
          if (r_idx == 7'd0) begin
            w_idx_nxt      = 7'(RESP_BYTES - 1);
            w_tx_valid_nxt = 1'b0;
            w_tx_data_nxt  = 8'h00;
            w_state_nxt    = WAIT_RESP;
          end else begin
            w_idx_nxt     = w_idx_m1;
            w_tx_data_nxt = r_hdr[{w_idx_m1, 3'b000} +: 8];
          end
        end
      end
      WAIT_RESP: begin
        if (w_rx_done) begin
          w_state_nxt = IDLE;
        end else if (w_to_hit) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_idx        <= 7'd0;
      r_hdr        <= '0;
      r_tx_data    <= 8'h00;
      r_tx_valid   <= 1'b0;
      r_hash       <= '0;
      r_hash_valid <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_tx_data    <= w_tx_data_nxt;
      r_tx_valid   <= w_tx_valid_nxt;
      r_hash_valid <= w_rx_done;
      r_timeout    <= w_timeout_nxt;
      if (w_hdr_load) r_hdr <= link.hdr_in;
      if (w_rx_done) r_hash <= w_rx_word;
    end
  end

  assign link.hdr_ready  = (r_state == IDLE);
  assign link.tx_data    = r_tx_data;
  assign link.tx_valid   = r_tx_valid;
  assign link.hash_out   = r_hash;
  assign link.hash_valid = r_hash_valid;
  assign link.busy       = (r_state != IDLE);
  assign link.timeout    = r_timeout;

endmodule
